// File: rtl/lsu.sv
// lsu: load/store unit between the core memory stage and the word-wide dmem.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests trap).
module lsu #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] alu_result,
    output logic [31:0] wdata,
    output logic        wmem,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(RD_LAT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] st_q, st_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        mis;
    logic        rd_last;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] st_word;

    assign req_ready = rst & (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign rd_last   = (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = ((req_size == 2'b01) & req_addr[0])
               | (req_size[1] & (|req_addr[1:0]));
`else
    assign mis = 1'b0;
`endif

    // Lane selection and extension of the word returned by dmem.
    always_comb begin
        ld_byte = 8'h00;
        ld_half = addr_q[1] ? rdata[31:16] : rdata[15:0];
        ld_ext  = rdata;
        unique case (addr_q[1:0])
            2'b00: ld_byte = rdata[7:0];
            2'b01: ld_byte = rdata[15:8];
            2'b10: ld_byte = rdata[23:16];
            2'b11: ld_byte = rdata[31:24];
        endcase
        unique case (1'b1)
            size_q[1]:
                ld_ext = rdata;
            (size_q == 2'b01):
                ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default:
                ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
        endcase
    end

    // Merge store data into the captured word for sub-word writes.
    always_comb begin
        st_word = word_q;
        unique case (1'b1)
            size_q[1]: begin
                st_word = st_q;
            end
            (size_q == 2'b01): begin
                if (addr_q[1])
                    st_word[31:16] = st_q[15:0];
                else
                    st_word[15:0] = st_q[15:0];
            end
            default: begin
                unique case (addr_q[1:0])
                    2'b00: st_word[7:0]   = st_q[7:0];
                    2'b01: st_word[15:8]  = st_q[7:0];
                    2'b10: st_word[23:16] = st_q[7:0];
                    2'b11: st_word[31:24] = st_q[7:0];
                endcase
            end
        endcase
    end

    // Next-state and datapath capture decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        st_d    = st_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (accept) begin
                    we_d   = req_we;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    addr_d = req_addr;
                    st_d   = req_wdata;
                    cnt_d  = 8'd0;
                    if (mis) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_we & req_size[1]) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (rd_last) begin
                    word_d = rdata;
                    if (we_q) begin
                        state_d = WR;
                    end else begin
                        rdata_d = ld_ext;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            st_q    <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            st_q    <= st_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign wmem       = (state_q == WR);
    assign wdata      = wmem ? st_word : 32'd0;
    assign alu_result = ((state_q != IDLE) && !err_q)
                      ? {addr_q[31:2], 2'b00} : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a registered-read word memory.
// Expected values are hand-computed for RD_LAT = 1.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] rdata;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    int          wm_n, wm_k, rv_n, rv_k;
    logic [31:0] wm_data, wm_addr, rv_data;
    logic        rv_err, alu_nz;

    lsu #(.RD_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .alu_result   (alu_result),
        .wdata        (wdata),
        .wmem         (wmem),
        .rdata        (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rdata = 32'd0;
    end

    always @(posedge clk) begin
        if (wmem) mem[alu_result[9:2]] <= wdata;
        rdata <= mem[alu_result[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd);
        int g;
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g == 20) chk("accept_timeout", 32'(g), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wm_n = 0; wm_k = 0; rv_n = 0; rv_k = 0;
        wm_data = 0; wm_addr = 0; rv_data = 0;
        rv_err = 0; alu_nz = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (alu_result != 32'd0) alu_nz = 1'b1;
            if (wmem) begin
                wm_n++;
                if (wm_n == 1) wm_k = k;
                wm_data = wdata;
                wm_addr = alu_result;
            end
            if (resp_valid) begin
                rv_n++;
                rv_k    = k;
                rv_data = resp_rdata;
                rv_err  = resp_err;
            end
        end
    endtask

    initial begin
        int          acc_k, n;
        logic        rdy_early;
        int          rk [0:3];
        logic [31:0] rd [0:3];

        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;

        // reset state
        @(negedge clk);
        chk("rst_ready_pre", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wmem", 32'(wmem), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // word store 0x100 <- A5A5A5A5
        run_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hA5A5A5A5);
        chk("sw_wmem_cnt", 32'(wm_n), 32'd1);
        chk("sw_wmem_cyc", 32'(wm_k), 32'd1);
        chk("sw_wdata", wm_data, 32'hA5A5A5A5);
        chk("sw_addr", wm_addr, 32'h100);
        chk("sw_resp_cyc", 32'(rv_k), 32'd2);
        chk("sw_resp_n", 32'(rv_n), 32'd1);

        // word load 0x100
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        chk("lw_resp_cyc", 32'(rv_k), 32'd3);
        chk("lw_data", rv_data, 32'hA5A5A5A5);
        chk("lw_no_wmem", 32'(wm_n), 32'd0);

        // byte store 0x102 <- 3C (read-modify-write)
        run_op(1'b1, 2'b00, 1'b0, 32'h102, 32'hFFFFFF3C);
        chk("sb_wmem_cnt", 32'(wm_n), 32'd1);
        chk("sb_wmem_cyc", 32'(wm_k), 32'd3);
        chk("sb_wdata", wm_data, 32'hA53CA5A5);
        chk("sb_resp_cyc", 32'(rv_k), 32'd4);
        chk("sb_rdata_hold", rv_data, 32'hA5A5A5A5);

        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        chk("lw2_data", rv_data, 32'hA53CA5A5);

        // half store 0x100 <- 3456, then half store 0x102 <- 8012
        run_op(1'b1, 2'b01, 1'b0, 32'h100, 32'h00003456);
        chk("sh_lo_wdata", wm_data, 32'hA53C3456);
        run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h00008012);
        chk("sh_hi_wdata", wm_data, 32'h80123456);

        // extension checks on 0x80123456
        run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        chk("lb_s_103", rv_data, 32'hFFFFFF80);
        run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        chk("lbu_103", rv_data, 32'h00000080);
        run_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        chk("lb_s_100", rv_data, 32'h00000056);
        run_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        chk("lhu_102", rv_data, 32'h00008012);
        run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        chk("lh_s_102", rv_data, 32'hFFFF8012);

        // misaligned half load at 0x101
        run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_resp_cyc", 32'(rv_k), 32'd1);
        chk("mis_err", 32'(rv_err), 32'd1);
        chk("mis_alu_nz", 32'(alu_nz), 32'd0);
        chk("mis_rdata_hold", rv_data, 32'hFFFF8012);
`else
        chk("mis_resp_cyc", 32'(rv_k), 32'd3);
        chk("mis_err", 32'(rv_err), 32'd0);
        chk("mis_data", rv_data, 32'h00003456);
`endif
        chk("mis_no_wmem", 32'(wm_n), 32'd0);

        // reset while a byte store is in its read phase
        @(negedge clk);
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h100;
        req_wdata = 32'h000000EE;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wm_n = 0;
        rv_n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (wmem) wm_n++;
            if (resp_valid) rv_n++;
            if (k == 2) rst = 1'b0;
            if (k == 3) rst = 1'b1;
        end
        chk("rstmid_wmem", 32'(wm_n), 32'd0);
        chk("rstmid_resp", 32'(rv_n), 32'd0);
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        chk("rstmid_readback", rv_data, 32'h80123456);

        // back-to-back with req_valid held high
        @(negedge clk);
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h100;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_size     = 2'b00;
        req_unsigned = 1'b1;
        req_addr     = 32'h101;
        acc_k     = 0;
        n         = 0;
        rdy_early = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 3 && req_ready) rdy_early = 1'b1;
            if (resp_valid && n < 4) begin
                rk[n] = k;
                rd[n] = resp_rdata;
                n++;
            end
            if (req_ready && req_valid && acc_k == 0) begin
                acc_k = k;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("b2b_ready_busy", 32'(rdy_early), 32'd0);
        chk("b2b_accept_cyc", 32'(acc_k), 32'd4);
        chk("b2b_resp_n", 32'(n), 32'd2);
        if (n == 2) begin
            chk("b2b_r0_cyc", 32'(rk[0]), 32'd3);
            chk("b2b_r0_data", rd[0], 32'h80123456);
            chk("b2b_r1_cyc", 32'(rk[1]), 32'd7);
            chk("b2b_r1_data", rd[1], 32'h00000034);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
